mesi_set_ctrl: RTL
==================

// Module: mesi_set_ctrl
// PURPOSE
//  Parametrised per-set MESI coherence controller for the L2: WAYS tag/state entries with true-LRU replacement.
//  Serves L1 requests and FSB snoops through a multi-cycle bus handshake, including victim writeback.
//  Sits between the L1BUS command decoder and the FSB arbiter; one instance per set index.
// PARAMETERS
//  WAYS   4   associativity, power of two, 2..16
//  TAG_W  12  tag width in bits
//  WAY_W  $clog2(WAYS)  way index width (derived, do not override)
// PORTS
//  CLK        in   1      clock
//  RST        in   1      synchronous, active-high reset
//  CMD_VALID  in   1      command present
//  CMD_READY  out  1      controller idle, accepts command
//  COMMAND    in   4      0 L1 data rd, 1 L1 wr, 2 L1 instr rd, 3 snoop inval, 4 snoop rd, 5 snoop wr, 6 snoop RFO, 8 clear
//  TAG        in   TAG_W  address tag of command
//  BUS_REQ    out  1      FSB request
//  BUS_OP     out  2      0 READ, 1 RFO, 2 WRITEBACK, 3 INVALIDATE
//  BUS_TAG    out  TAG_W  tag of the bus operation (victim tag on WRITEBACK)
//  BUS_GNT    in   1      FSB grant, one-cycle pulse
//  HM_VALID   in   1      snoop result valid, one-cycle pulse
//  HM         in   2      0 MISS, 1 HIT, 2/3 HITM
//  SNOOP_HM   out  2      this cache's snoop response, valid with DONE
//  DONE       out  1      command complete, one-cycle pulse
//  HIT        out  1      tag matched a valid way, valid with DONE
//  WAY        out  WAY_W  way used, valid with DONE
//  STATE      out  4      resulting one-hot MESI state: M 0001, E 0010, S 0100, I 1000
// BEHAVIOUR
//  Reset: all ways INVALID, LRU ages = way index, FSM IDLE; CMD_READY=1; all other outputs 0; STATE=1000.
//  RST mid-operation aborts the transaction: BUS_REQ drops at that edge, no state update, no DONE.
//  FSM: IDLE -> LOOKUP -> {DONE_ST | WB_REQ | BUS_REQ_ST} ; WB_REQ -> WB_GNT -> BUS_REQ_ST ; BUS_REQ_ST -> WAIT_HM -> DONE_ST -> IDLE.
//  IDLE: CMD_READY=1; command and TAG are registered on CMD_VALID. CMD_READY=0 in every other state.
//  LOOKUP (1 cycle): parallel tag compare over non-INVALID ways; at most one match by construction.
//  Read hit (0/2), any valid state: DONE next cycle, state unchanged; total latency 2 cycles from accept.
//  Write hit: M stays M; E -> M silently; S issues BUS_OP=INVALIDATE, waits BUS_GNT, -> M (no HM wait).
//  Miss (0/1/2): victim = lowest-index INVALID way, else LRU way. Victim M -> WRITEBACK with victim tag, wait BUS_GNT.
//  Fill: BUS_OP READ (0/2) or RFO (1); BUS_REQ held until BUS_GNT, then wait HM_VALID.
//  Fill result: READ with HM=0 -> E, HM!=0 -> S; RFO -> M regardless of HM. Tag written at DONE.
//  LRU: on any L1 command (0/1/2) used way gets age 0; ways younger than it age by 1. Snoops and clear do not touch LRU.
//  Snoops (3..6) never use the bus; DONE in 2 cycles, HIT/WAY report match, SNOOP_HM: 2 if line was M, 1 if E/S, 0 on miss.
//  Snoop transitions: 3: S/E -> I, M unchanged. 4: M/E -> S. 5: no change. 6: all -> I.
//  Command 8: all ways -> I, LRU reset to reset values, DONE after 2 cycles, HIT=0.
//  Commands 7, 9..15: DONE after 2 cycles, no state change, HIT=0, STATE=1000.
//  BUS_GNT/HM_VALID outside the waiting state are ignored. HM=3 is treated as HITM.
//  DONE, HIT, WAY, STATE and SNOOP_HM are registered and change only on DONE.
// CONFIGURATION
//  MESI_SET_STATS_EN defined: adds outputs HIT_CNT and MISS_CNT (32 bits each), counting L1 commands 0/1/2 at DONE,
//    saturating at 0xFFFFFFFF, cleared by RST and by command 8.
//  Not defined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//  Read miss into empty set, HM=0 -> WAY=0, STATE=0010, BUS_OP=0 seen once, HIT=0.
//  Same tag read again -> DONE 2 cycles after accept, HIT=1, STATE=0010, BUS_REQ stays 0.
//  Write to the S line of a snooped read (HM=1 fill) -> BUS_OP=3, after BUS_GNT STATE=0001.
//  WAYS=4: fill tags 1..4, touch tag 1, write tag 2 (M), miss tag 5 -> victim way for tag 3 is way 2, no WB;
//    then evict the M line -> BUS_OP=2 with BUS_TAG=2 before the READ.
//  Snoop RFO (6) on an M line -> SNOOP_HM=2, line INVALID; later read of same tag misses.
//  RST asserted while in WAIT_HM -> next cycle CMD_READY=1, BUS_REQ=0, all ways INVALID.

Source files
------------

// File: rtl/mesi_set_ctrl.sv
// rtl/mesi_set_ctrl.sv - per-set MESI coherence controller with true-LRU replacement
// Optional hit/miss counters are enabled by defining MESI_SET_STATS_EN.
module mesi_set_ctrl #(
   parameter int WAYS  = 4,
   parameter int TAG_W = 12,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [3:0]       COMMAND,
   input  logic [TAG_W-1:0] TAG,
   output logic             BUS_REQ,
   output logic [1:0]       BUS_OP,
   output logic [TAG_W-1:0] BUS_TAG,
   input  logic             BUS_GNT,
   input  logic             HM_VALID,
   input  logic [1:0]       HM,
   output logic [1:0]       SNOOP_HM,
   output logic             DONE,
   output logic             HIT,
   output logic [WAY_W-1:0] WAY,
   output logic [3:0]       STATE
`ifdef MESI_SET_STATS_EN
   ,
   output logic [31:0]      HIT_CNT,
   output logic [31:0]      MISS_CNT
`endif
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_GNT, S_BUS_REQ, S_WAIT_HM, S_DONE
   } fsm_e;

   localparam logic [3:0] ST_M = 4'b0001, ST_E = 4'b0010, ST_S = 4'b0100, ST_I = 4'b1000;
   localparam logic [1:0] OP_READ = 2'd0, OP_RFO = 2'd1, OP_WB = 2'd2, OP_INV = 2'd3;
   localparam logic [3:0] CMD_WR = 4'd1, CMD_CLR = 4'd8;

   fsm_e             state_q, state_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [TAG_W-1:0] ctag_q, ctag_d;
   logic [WAY_W-1:0] sel_q, sel_d;
   logic             rdy_q, rdy_d;
   logic             bus_req_q, bus_req_d;
   logic [1:0]       bus_op_q, bus_op_d;
   logic [TAG_W-1:0] bus_tag_q, bus_tag_d;
   logic             done_q, done_d, hit_q, hit_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic [3:0]       line_st_q, line_st_d;
   logic [1:0]       snoop_hm_q, snoop_hm_d;
   logic [3:0]       mesi_q [WAYS];
   logic [3:0]       mesi_d [WAYS];
   logic [TAG_W-1:0] tags_q [WAYS];
   logic [TAG_W-1:0] tags_d [WAYS];
   logic [WAY_W-1:0] age_q  [WAYS];
   logic [WAY_W-1:0] age_d  [WAYS];

   logic             lk_hit, inv_found, is_l1, is_snoop;
   logic [WAY_W-1:0] lk_way, inv_way, lru_way, victim;
   logic [3:0]       cur;
   logic [1:0]       fill_op;
   logic             fin, wr_en, wr_tag, touch, clr;
   logic [WAY_W-1:0] wr_way;
   logic [3:0]       wr_st;

   assign is_l1    = (cmd_q <= 4'd2);
   assign is_snoop = (cmd_q >= 4'd3) && (cmd_q <= 4'd6);
   assign victim   = inv_found ? inv_way : lru_way;
   assign cur      = mesi_q[lk_way];
   assign fill_op  = (cmd_q == CMD_WR) ? OP_RFO : OP_READ;

   always_comb begin
      lk_hit    = 1'b0;
      lk_way    = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (mesi_q[i] != ST_I && tags_q[i] == ctag_q) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(i);
         end
         if (mesi_q[i] == ST_I && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(i);
         end
         if (age_q[i] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;  cmd_d = cmd_q;  ctag_d = ctag_q;  sel_d = sel_q;
      bus_req_d = bus_req_q;  bus_op_d = bus_op_q;  bus_tag_d = bus_tag_q;
      done_d = 1'b0;  hit_d = hit_q;  way_d = way_q;
      line_st_d = line_st_q;  snoop_hm_d = snoop_hm_q;
      fin = 1'b0;  wr_en = 1'b0;  wr_tag = 1'b0;  touch = 1'b0;  clr = 1'b0;
      wr_way = sel_q;  wr_st = ST_I;
      case (state_q)
         S_IDLE: if (CMD_VALID) begin
            cmd_d   = COMMAND;
            ctag_d  = TAG;
            state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (is_l1 && lk_hit) begin
               sel_d = lk_way;
               if (cmd_q == CMD_WR && cur == ST_S) begin
                  bus_op_d  = OP_INV;
                  bus_tag_d = ctag_q;
                  state_d   = S_BUS_REQ;
               end else begin
                  fin = 1'b1;  wr_en = 1'b1;  wr_way = lk_way;  touch = 1'b1;
                  hit_d = 1'b1;  way_d = lk_way;
                  wr_st = (cmd_q == CMD_WR) ? ST_M : cur;
               end
            end else if (is_l1) begin
               sel_d = victim;
               if (mesi_q[victim] == ST_M) begin
                  bus_op_d  = OP_WB;
                  bus_tag_d = tags_q[victim];
                  state_d   = S_WB_REQ;
               end else begin
                  bus_op_d  = fill_op;
                  bus_tag_d = ctag_q;
                  state_d   = S_BUS_REQ;
               end
            end else begin
               fin = 1'b1;  hit_d = 1'b0;  way_d = '0;  snoop_hm_d = 2'd0;
               if (is_snoop && lk_hit) begin
                  hit_d = 1'b1;  way_d = lk_way;  wr_en = 1'b1;  wr_way = lk_way;
                  snoop_hm_d = (cur == ST_M) ? 2'd2 : 2'd1;
                  case (cmd_q)
                     4'd3:    wr_st = (cur == ST_M) ? ST_M : ST_I;
                     4'd4:    wr_st = ST_S;
                     4'd6:    wr_st = ST_I;
                     default: wr_st = cur;
                  endcase
               end
               clr = (cmd_q == CMD_CLR);
            end
         end
         S_WB_REQ: begin
            bus_req_d = 1'b1;
            state_d   = S_WB_GNT;
         end
         S_WB_GNT: if (BUS_GNT) begin
            bus_req_d = 1'b0;
            bus_op_d  = fill_op;
            bus_tag_d = ctag_q;
            state_d   = S_BUS_REQ;
         end
         S_BUS_REQ: begin
            // Request rises one cycle after entry so a grant can never be stale.
            if (bus_req_q && BUS_GNT) begin
               bus_req_d = 1'b0;
               if (bus_op_q == OP_INV) begin
                  fin = 1'b1;  wr_en = 1'b1;  wr_st = ST_M;  touch = 1'b1;
                  hit_d = 1'b1;  way_d = sel_q;
               end else begin
                  state_d = S_WAIT_HM;
               end
            end else begin
               bus_req_d = 1'b1;
            end
         end
         S_WAIT_HM: if (HM_VALID) begin
            fin = 1'b1;  wr_en = 1'b1;  wr_tag = 1'b1;  touch = 1'b1;
            hit_d = 1'b0;  way_d = sel_q;
            wr_st = (bus_op_q == OP_RFO) ? ST_M : ((HM == 2'd0) ? ST_E : ST_S);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d   = S_DONE;
         done_d    = 1'b1;
         line_st_d = wr_en ? wr_st : ST_I;
         if (!is_snoop) snoop_hm_d = 2'd0;
      end

      for (int i = 0; i < WAYS; i++) begin
         mesi_d[i] = mesi_q[i];
         tags_d[i] = tags_q[i];
         age_d[i]  = age_q[i];
      end
      if (wr_en)  mesi_d[wr_way] = wr_st;
      if (wr_tag) tags_d[wr_way] = ctag_q;
      if (touch) begin
         for (int i = 0; i < WAYS; i++)
            if (age_q[i] < age_q[wr_way]) age_d[i] = age_q[i] + 1'b1;
         age_d[wr_way] = '0;
      end
      if (clr) begin
         for (int i = 0; i < WAYS; i++) begin
            mesi_d[i] = ST_I;
            age_d[i]  = WAY_W'(i);
         end
      end
      rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;  cmd_q <= '0;  ctag_q <= '0;  sel_q <= '0;  rdy_q <= 1'b1;
         bus_req_q <= 1'b0;  bus_op_q <= '0;  bus_tag_q <= '0;
         done_q <= 1'b0;  hit_q <= 1'b0;  way_q <= '0;  line_st_q <= ST_I;  snoop_hm_q <= '0;
         for (int i = 0; i < WAYS; i++) begin
            mesi_q[i] <= ST_I;
            tags_q[i] <= '0;
            age_q[i]  <= WAY_W'(i);
         end
      end else begin
         state_q <= state_d;  cmd_q <= cmd_d;  ctag_q <= ctag_d;  sel_q <= sel_d;  rdy_q <= rdy_d;
         bus_req_q <= bus_req_d;  bus_op_q <= bus_op_d;  bus_tag_q <= bus_tag_d;
         done_q <= done_d;  hit_q <= hit_d;  way_q <= way_d;
         line_st_q <= line_st_d;  snoop_hm_q <= snoop_hm_d;
         for (int i = 0; i < WAYS; i++) begin
            mesi_q[i] <= mesi_d[i];
            tags_q[i] <= tags_d[i];
            age_q[i]  <= age_d[i];
         end
      end
   end

`ifdef MESI_SET_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (fin && is_l1) begin
         if (hit_d && hit_cnt_q != 32'hFFFF_FFFF)        hit_cnt_d  = hit_cnt_q + 32'd1;
         else if (!hit_d && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
      if (fin && cmd_q == CMD_CLR) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign HIT_CNT  = hit_cnt_q;
   assign MISS_CNT = miss_cnt_q;
`endif

   assign CMD_READY = rdy_q;
   assign BUS_REQ   = bus_req_q;
   assign BUS_OP    = bus_op_q;
   assign BUS_TAG   = bus_tag_q;
   assign SNOOP_HM  = snoop_hm_q;
   assign DONE      = done_q;
   assign HIT       = hit_q;
   assign WAY       = way_q;
   assign STATE     = line_st_q;
endmodule
